// File: rtl/field_access_ctrl.sv
// Arbiter and sequencer for the single-port cell-field RAM: ant read-modify-write accesses,
// display pixel reads and a clear engine that zeroes every cell after reset or on request.
module field_access_ctrl #(
  parameter int unsigned C_NUM_OF_CELLS_X = 5,
  parameter int unsigned C_NUM_OF_CELLS_Y = 5,
  parameter int unsigned C_ANT_MAX_WAIT   = 4
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        iclear,
  output logic        oclear_busy,
  input  logic        idisp_req,
  input  logic [15:0] idisp_addr,
  output logic        odisp_ack,
  output logic        odisp_valid,
  output logic        odisp_data,
  input  logic        iant_req,
  input  logic        iant_we,
  input  logic [15:0] iant_addr,
  input  logic        iant_wdata,
  output logic        oant_ack,
  output logic        oant_valid,
  output logic        oant_rdata,
  output logic [15:0] oaddr,
  output logic        owr_en,
  output logic        owr_data,
  output logic        ord_en,
  input  logic        ird_data
);

  localparam int unsigned NumCells = C_NUM_OF_CELLS_X * C_NUM_OF_CELLS_Y;
  localparam int unsigned StarveW  = (C_ANT_MAX_WAIT < 1) ? 1 : $clog2(C_ANT_MAX_WAIT + 1);
  localparam logic [15:0]        LastCell    = 16'(NumCells - 1);
  localparam logic [16:0]        NumCellsExt = 17'(NumCells);
  localparam logic [StarveW-1:0] StarveMax   = StarveW'(C_ANT_MAX_WAIT);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  // Travels alongside each read until its data returns from the RAM.
  typedef struct packed {
    logic valid;
    logic ant;
    logic oor;
  } tag_t;

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [15:0]        addr_q, addr_d;
  logic               wr_en_q, wr_en_d;
  logic               wr_data_q, wr_data_d;
  logic               rd_en_q, rd_en_d;
  tag_t               tag1_q, tag1_d;
  tag_t               tag2_q;

  logic        ant_force;
  logic        disp_grant;
  logic        ant_grant;
  logic [15:0] gnt_addr;
  logic        gnt_we;
  logic        in_range;
  logic        read_bit;

  // Arbitration: display first unless the ant has waited its limit.
  always_comb begin
    ant_force  = 1'b0;
    disp_grant = 1'b0;
    ant_grant  = 1'b0;
    if (state_q == StRun) begin
      ant_force  = iant_req && (starve_q == StarveMax);
      disp_grant = idisp_req && !ant_force;
      ant_grant  = iant_req && !disp_grant;
    end
  end

  always_comb begin
    gnt_addr = disp_grant ? idisp_addr : iant_addr;
    gnt_we   = ant_grant && iant_we;
    in_range = ({1'b0, gnt_addr} < NumCellsExt);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    tag1_d    = '0;
    starve_d  = '0;
    unique case (state_q)
      StClear: begin
        addr_d    = cnt_q;
        wr_en_d   = 1'b1;
        wr_data_d = 1'b0;
        if (iclear) begin
          cnt_d = '0;
        end else if (cnt_q == LastCell) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StRun: begin
        if (disp_grant || ant_grant) begin
          addr_d = gnt_addr;
          if (gnt_we) begin
            wr_en_d   = in_range;
            wr_data_d = iant_wdata;
          end else begin
            // Out-of-range reads skip the RAM but still return a zero.
            rd_en_d      = in_range;
            tag1_d.valid = 1'b1;
            tag1_d.ant   = ant_grant;
            tag1_d.oor   = !in_range;
          end
        end
        if (iant_req && !ant_grant) begin
          starve_d = starve_q + 1'b1;
        end
        if (iclear) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q   <= StClear;
      cnt_q     <= '0;
      starve_q  <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 1'b0;
      rd_en_q   <= 1'b0;
      tag1_q    <= '0;
      tag2_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      tag1_q    <= tag1_d;
      tag2_q    <= tag1_q;
    end
  end

  always_comb begin
    read_bit    = !tag2_q.oor && ird_data;
    oclear_busy = (state_q == StClear);
    odisp_ack   = disp_grant;
    oant_ack    = ant_grant;
    odisp_valid = tag2_q.valid && !tag2_q.ant;
    oant_valid  = tag2_q.valid && tag2_q.ant;
    odisp_data  = odisp_valid && read_bit;
    oant_rdata  = oant_valid && read_bit;
    oaddr       = addr_q;
    owr_en      = wr_en_q;
    owr_data    = wr_data_q;
    ord_en      = rd_en_q;
  end

endmodule

// File: doc/field_access_ctrl.md
Name: field_access_ctrl

Overview:
Sequences and shares the single-port cell-field RAM between the ant step FSM (read-modify-write of the current cell) and the display scanner (per-pixel cell colour reads). It also runs a clear engine that zeroes every cell after reset and on request. It sits between the requesters and the field memory and owns the memory address, write-enable and read-enable lines.

Parameters:
C_NUM_OF_CELLS_X, 5, cells per row
C_NUM_OF_CELLS_Y, 5, cells per column; N = C_NUM_OF_CELLS_X*C_NUM_OF_CELLS_Y, valid addresses 0..N-1
C_ANT_MAX_WAIT, 4, consecutive denied cycles after which the ant requester is forced to win

Ports:
iclk  in  1  system clock, all logic on rising edge
irst  in  1  asynchronous reset, active-high
iclear  in  1  single-cycle pulse: restart the clear engine
oclear_busy  out  1  high while the clear engine owns the memory
idisp_req  in  1  display read request; held with idisp_addr stable until odisp_ack
idisp_addr  in  16  display cell address
odisp_ack  out  1  combinational grant, same cycle as the accepted request
odisp_valid  out  1  registered, 2 cycles after odisp_ack
odisp_data  out  1  cell value, qualified by odisp_valid
iant_req  in  1  ant request; held with iant_we, iant_addr and iant_wdata stable until oant_ack
iant_we  in  1  1 = write, 0 = read
iant_addr  in  16  ant cell address
iant_wdata  in  1  write value
oant_ack  out  1  combinational grant
oant_valid  out  1  read data valid, 2 cycles after a read ack; never asserted for writes
oant_rdata  out  1  cell value, qualified by oant_valid
oaddr  out  16  memory address, registered
owr_en  out  1  memory write enable, registered
owr_data  out  1  memory write data, registered
ord_en  out  1  memory read enable, registered
ird_data  in  1  memory read data, valid 1 cycle after ord_en

Behaviour:
- The RAM is synchronous: a command on oaddr/owr_en/ord_en at cycle T is performed at the T edge, and ird_data is valid at T+1.
- States: S_CLEAR and S_RUN. Reset forces S_CLEAR with the clear counter at 0.
- oclear_busy = (state==S_CLEAR). It is therefore 1 during reset.
- In reset, oaddr, owr_en, owr_data, ord_en, odisp_valid, odisp_data, oant_valid, oant_rdata and the starvation counter are all 0.
- S_CLEAR, per cycle: register oaddr=cnt, owr_en=1, owr_data=0, ord_en=0; then cnt++.
  - After issuing cnt=N-1, go to S_RUN. A clear takes exactly N cycles.
  - No acks are given in S_CLEAR.
- iclear in S_RUN: enter S_CLEAR with cnt=0 on the next cycle. Any ack given in that same cycle still completes.
- iclear in S_CLEAR: restart with cnt=0.
- S_RUN arbitration, one grant per cycle:
  - Default priority: display over ant.
  - Starvation counter increments each cycle iant_req=1 && oant_ack=0. It clears on oant_ack, in S_CLEAR, and whenever iant_req=0.
  - When the counter equals C_ANT_MAX_WAIT, the ant wins over the display.
- Granted request: the ack is asserted combinationally in cycle T, and the memory command is registered for cycle T+1.
  - Write: owr_en=1, owr_data=iant_wdata, ord_en=0.
  - Read: ord_en=1, owr_en=0.
  - With no grant, owr_en=ord_en=0 and oaddr holds its value.
- Read return: a 2-deep tag pipeline (requester id, out-of-range flag) follows each read.
  - At T+2 the tagged requester's valid pulses for 1 cycle, and its data = ird_data.
  - Reads already in flight complete even if a clear starts.
- A requester may present its next request in the cycle after its ack, giving a back-to-back throughput of 1 per cycle.
- Out-of-range address (>= N):
  - Still acked.
  - A write is suppressed (owr_en=0).
  - A read issues ord_en=0 and returns valid with data 0 at T+2.
- Address width: compare the full 16-bit address against N. No wrap-around.
- Asynchronous reset mid-operation aborts everything. In-flight reads produce no valid, and a full clear follows.

Test Plan:
- Reset release, N=25: oclear_busy=1 for exactly 25 cycles; oaddr steps 0..24 with owr_en=1, owr_data=0; then oclear_busy=0 and no memory activity while idle.
- Ant write addr 7 data 1, then ant read addr 7: each oant_ack comes the same cycle as its request; write appears on the memory port the next cycle; oant_valid pulses 2 cycles after the read ack with oant_rdata=1; no oant_valid for the write.
- Display req held high continuously plus ant req held (C_ANT_MAX_WAIT=4): display acked for 4 cycles, ant acked on the 5th, then display resumes; pattern repeats.
- Simultaneous single requests with the ant counter below the limit: odisp_ack=1, oant_ack=0; ant acked the following cycle.
- iclear pulse one cycle after an ant read ack on addr 3 (cell=1): oant_valid=1, data=1 still delivered; then 25 clear cycles; subsequent read of addr 3 returns 0.
- Ant write to addr 30 and display read of addr 25: both acked; owr_en stays 0; display valid with data 0; memory contents unchanged.
